// File: rtl/ex_mem_stage_if.sv
// -----------------------------------------------------------------------------
// ex_mem_stage_if
// Bundle of every signal exchanged between the pipeline and the EX/MEM stage.
//
// Modports
//   master : pipeline side. Drives the stage controls (stall, flush), the EX
//            inputs, the ALU flags and the forwarding inputs. Receives the
//            EM outputs and shadow_cnt.
//   slave  : EX/MEM stage side. The directions are the reverse of master.
//
// Signals (widths)
//   stall, flush                                  1   hold / kill requests
//   ie_valid, ie_mem_write, ie_mem_read,
//   ie_reg_write, ie_mem_to_reg, ie_reg_dst       1   EX control bits
//   ie_branch_op                                  3   branch type
//   ie_jump                                       2   jump type
//   alu_zero, alu_sign                            1   branch compare flags
//   ie_pc_plus4, ie_sign_imm, alu_result,
//   ie_reg_data2, mw_wb_data                      DW  EX datapath
//   ie_jaddr                                      26  jump target field
//   ie_rt, ie_rd                                  AW  destination candidates
//   fw_wd_sel                                     2   store-data source select
//   em_*                                          registered stage outputs
//   shadow_cnt                                    3   remaining kill slots
// -----------------------------------------------------------------------------
interface ex_mem_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          stall;
    logic          flush;

    logic          ie_valid;
    logic          ie_mem_write;
    logic          ie_mem_read;
    logic          ie_reg_write;
    logic          ie_mem_to_reg;
    logic          ie_reg_dst;
    logic [2:0]    ie_branch_op;
    logic [1:0]    ie_jump;
    logic          alu_zero;
    logic          alu_sign;
    logic [DW-1:0] ie_pc_plus4;
    logic [DW-1:0] ie_sign_imm;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] ie_reg_data2;
    logic [DW-1:0] mw_wb_data;
    logic [25:0]   ie_jaddr;
    logic [AW-1:0] ie_rt;
    logic [AW-1:0] ie_rd;
    logic [1:0]    fw_wd_sel;

    logic          em_valid;
    logic          em_mem_write;
    logic          em_mem_read;
    logic          em_reg_write;
    logic          em_mem_to_reg;
    logic          em_redirect;
    logic [1:0]    em_jump;
    logic [25:0]   em_jaddr;
    logic [AW-1:0] em_wb_addr;
    logic [DW-1:0] em_alu_result;
    logic [DW-1:0] em_write_data;
    logic [DW-1:0] em_pc_branch;
    logic [DW-1:0] em_pc_plus4;
    logic [2:0]    shadow_cnt;

    modport master (
        output stall, flush,
        output ie_valid, ie_mem_write, ie_mem_read, ie_reg_write,
        output ie_mem_to_reg, ie_reg_dst, ie_branch_op, ie_jump,
        output alu_zero, alu_sign,
        output ie_pc_plus4, ie_sign_imm, alu_result, ie_reg_data2, mw_wb_data,
        output ie_jaddr, ie_rt, ie_rd, fw_wd_sel,
        input  em_valid, em_mem_write, em_mem_read, em_reg_write,
        input  em_mem_to_reg, em_redirect, em_jump, em_jaddr, em_wb_addr,
        input  em_alu_result, em_write_data, em_pc_branch, em_pc_plus4,
        input  shadow_cnt
    );

    modport slave (
        input  stall, flush,
        input  ie_valid, ie_mem_write, ie_mem_read, ie_reg_write,
        input  ie_mem_to_reg, ie_reg_dst, ie_branch_op, ie_jump,
        input  alu_zero, alu_sign,
        input  ie_pc_plus4, ie_sign_imm, alu_result, ie_reg_data2, mw_wb_data,
        input  ie_jaddr, ie_rt, ie_rd, fw_wd_sel,
        output em_valid, em_mem_write, em_mem_read, em_reg_write,
        output em_mem_to_reg, em_redirect, em_jump, em_jaddr, em_wb_addr,
        output em_alu_result, em_write_data, em_pc_branch, em_pc_plus4,
        output shadow_cnt
    );
endinterface

// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register. It resolves branches, computes the branch target,
// selects the store data and squashes the SHADOW captures that follow a taken
// branch or a jump.
//
// Parameters
//   DW     : datapath width (32 or 64)
//   AW     : register-address width
//   SHADOW : number of captures killed after a redirect (1..7)
//
// Ports
//   clk : the only clock; all state changes on its rising edge
//   rst : synchronous, active-high reset
//   bus : ex_mem_stage_if.slave. Carries the EX inputs, stall/flush and the
//         registered EM outputs, including shadow_cnt.
//
// Update priority at each edge: rst > flush > stall > capture.
// -----------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int SHADOW = 1
) (
    input  logic            clk,
    input  logic            rst,
    ex_mem_stage_if.slave   bus
);
    localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW);

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BGTZ = 3'b011,
        BR_BLEZ = 3'b100
    } branch_op_e;

    logic          r_valid;
    logic          r_mem_write;
    logic          r_mem_read;
    logic          r_reg_write;
    logic          r_mem_to_reg;
    logic          r_redirect;
    logic [1:0]    r_jump;
    logic [25:0]   r_jaddr;
    logic [AW-1:0] r_wb_addr;
    logic [DW-1:0] r_alu_result;
    logic [DW-1:0] r_write_data;
    logic [DW-1:0] r_pc_branch;
    logic [DW-1:0] r_pc_plus4;
    logic [2:0]    r_shadow_cnt;

    logic          w_live;
    logic          w_taken;
    logic          w_redirect_start;
    logic [DW-1:0] w_write_data;
    logic [DW-1:0] w_pc_branch;
    logic [AW-1:0] w_wb_addr;

    // An instruction commits only when the shadow of an earlier redirect is
    // empty. Inside the shadow it is captured as a bubble.
    assign w_live           = bus.ie_valid && (r_shadow_cnt == 3'd0);
    assign w_redirect_start = w_live && (w_taken || (bus.ie_jump != 2'b00));
    assign w_pc_branch      = bus.ie_pc_plus4 + (bus.ie_sign_imm << 2);
    assign w_wb_addr        = bus.ie_reg_dst ? bus.ie_rd : bus.ie_rt;

    // NOTE: every signal driven in always_comb gets a default first, so an
    // uncovered case cannot infer a latch.
    always_comb begin
        w_taken = 1'b0;
        case (branch_op_e'(bus.ie_branch_op))
            BR_BEQ:  w_taken = bus.alu_zero;
            BR_BNE:  w_taken = !bus.alu_zero;
            BR_BGTZ: w_taken = !bus.alu_sign && !bus.alu_zero;
            BR_BLEZ: w_taken = bus.alu_sign || bus.alu_zero;
            default: w_taken = 1'b0;
        endcase
    end

    // Select 1 forwards the ALU result held in this stage, which is the value
    // before the current edge. It is the producer one instruction ahead.
    always_comb begin
        w_write_data = '0;
        case (bus.fw_wd_sel)
            2'd0:    w_write_data = bus.ie_reg_data2;
            2'd1:    w_write_data = r_alu_result;
            2'd2:    w_write_data = bus.mw_wb_data;
            default: w_write_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. The select-1 path
    // reads r_alu_result in the same edge that overwrites it, and it still
    // sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_redirect   <= 1'b0;
            r_jump       <= 2'b00;
            r_jaddr      <= '0;
            r_wb_addr    <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_branch  <= '0;
            r_pc_plus4   <= '0;
            r_shadow_cnt <= 3'd0;
        end else if (bus.flush) begin
            // Kill the control bits only. The datapath values are
            // meaningless without em_valid, so they hold.
            r_valid      <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_redirect   <= 1'b0;
            r_jump       <= 2'b00;
            r_shadow_cnt <= 3'd0;
        end else if (!bus.stall) begin
            r_valid      <= w_live;
            r_mem_write  <= bus.ie_mem_write && w_live;
            r_mem_read   <= bus.ie_mem_read  && w_live;
            r_reg_write  <= bus.ie_reg_write && w_live;
            r_redirect   <= w_taken && w_live;
            r_jump       <= w_live ? bus.ie_jump : 2'b00;
            r_mem_to_reg <= bus.ie_mem_to_reg;
            r_jaddr      <= bus.ie_jaddr;
            r_wb_addr    <= w_wb_addr;
            r_alu_result <= bus.alu_result;
            r_write_data <= w_write_data;
            r_pc_branch  <= w_pc_branch;
            r_pc_plus4   <= bus.ie_pc_plus4;
            // Every capture inside the shadow uses up one slot, including a
            // bubble.
            if (w_redirect_start) begin
                r_shadow_cnt <= SHADOW_LOAD;
            end else if (r_shadow_cnt != 3'd0) begin
                r_shadow_cnt <= r_shadow_cnt - 3'd1;
            end
        end
    end

    assign bus.em_valid      = r_valid;
    assign bus.em_mem_write  = r_mem_write;
    assign bus.em_mem_read   = r_mem_read;
    assign bus.em_reg_write  = r_reg_write;
    assign bus.em_mem_to_reg = r_mem_to_reg;
    assign bus.em_redirect   = r_redirect;
    assign bus.em_jump       = r_jump;
    assign bus.em_jaddr      = r_jaddr;
    assign bus.em_wb_addr    = r_wb_addr;
    assign bus.em_alu_result = r_alu_result;
    assign bus.em_write_data = r_write_data;
    assign bus.em_pc_branch  = r_pc_branch;
    assign bus.em_pc_plus4   = r_pc_plus4;
    assign bus.shadow_cnt    = r_shadow_cnt;
endmodule

// File: tb/tb_ex_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage, built with DW=32, AW=5 and SHADOW=3.
// Inputs change 1 ns after a rising edge and outputs are sampled at that same
// point, so every step is exactly one edge.
// -----------------------------------------------------------------------------
module tb_ex_mem_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_mem_stage_if #(.DW(32), .AW(5)) bus ();

    ex_mem_stage #(.DW(32), .AW(5), .SHADOW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.ie_valid      = 1'b0;
        bus.ie_mem_write  = 1'b0;
        bus.ie_mem_read   = 1'b0;
        bus.ie_reg_write  = 1'b0;
        bus.ie_mem_to_reg = 1'b0;
        bus.ie_reg_dst    = 1'b0;
        bus.ie_branch_op  = 3'b000;
        bus.ie_jump       = 2'b00;
        bus.alu_zero      = 1'b0;
        bus.alu_sign      = 1'b0;
        bus.ie_pc_plus4   = '0;
        bus.ie_sign_imm   = '0;
        bus.alu_result    = '0;
        bus.ie_reg_data2  = '0;
        bus.mw_wb_data    = '0;
        bus.ie_jaddr      = '0;
        bus.ie_rt         = '0;
        bus.ie_rd         = '0;
        bus.fw_wd_sel     = 2'd0;
    endtask

    // Clears the shadow in one edge with a flush.
    task automatic drain();
        clear_in();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        checks   = 0;
        failures = 0;
        clear_in();

        // Reset must override live inputs, stall and flush.
        rst = 1'b1;
        bus.ie_valid     = 1'b1;
        bus.ie_reg_write = 1'b1;
        bus.ie_jump      = 2'b01;
        bus.alu_result   = 32'h55;
        bus.stall        = 1'b1;
        step();
        check("rst_valid",     bus.em_valid, 0);
        check("rst_reg_write", bus.em_reg_write, 0);
        check("rst_jump",      bus.em_jump, 0);
        check("rst_alu",       bus.em_alu_result, 0);
        check("rst_pc_branch", bus.em_pc_branch, 0);
        check("rst_shadow",    bus.shadow_cnt, 0);
        rst = 1'b0;
        clear_in();

        // Taken bne: redirect, branch target 0x100 + (4<<2) = 0x110.
        bus.ie_valid     = 1'b1;
        bus.ie_branch_op = 3'b010;
        bus.alu_zero     = 1'b0;
        bus.ie_pc_plus4  = 32'h100;
        bus.ie_sign_imm  = 32'h4;
        bus.ie_reg_write = 1'b1;
        bus.ie_reg_dst   = 1'b1;
        bus.ie_rd        = 5'd3;
        bus.ie_rt        = 5'd7;
        bus.alu_result   = 32'h11;
        bus.ie_reg_data2 = 32'h77;
        bus.ie_jaddr     = 26'h123456;
        step();
        check("bne_redirect",  bus.em_redirect, 1);
        check("bne_pc_branch", bus.em_pc_branch, 32'h110);
        check("bne_valid",     bus.em_valid, 1);
        check("bne_wb_rd",     bus.em_wb_addr, 3);
        check("bne_wdata",     bus.em_write_data, 32'h77);
        check("bne_jaddr",     bus.em_jaddr, 26'h123456);
        check("bne_pc4",       bus.em_pc_plus4, 32'h100);
        check("bne_shadow",    bus.shadow_cnt, 3);
        clear_in();
        bus.ie_valid     = 1'b1;
        bus.ie_reg_write = 1'b1;
        bus.alu_result   = 32'h22;
        bus.ie_rt        = 5'd9;
        step();
        check("bne_kill_valid", bus.em_valid, 0);
        check("bne_kill_rw",    bus.em_reg_write, 0);
        check("bne_kill_redir", bus.em_redirect, 0);
        check("bne_kill_alu",   bus.em_alu_result, 32'h22);
        check("bne_kill_wb_rt", bus.em_wb_addr, 9);
        check("bne_kill_sh",    bus.shadow_cnt, 2);
        // Bubbles also use up shadow slots.
        clear_in();
        step();
        check("bubble_sh1", bus.shadow_cnt, 1);
        step();
        check("bubble_sh0", bus.shadow_cnt, 0);
        step();
        check("bubble_sh_floor", bus.shadow_cnt, 0);

        // Jump, then 4 reg_write instructions: the first three are killed.
        bus.ie_valid = 1'b1;
        bus.ie_jump  = 2'b01;
        step();
        check("jmp_jump",   bus.em_jump, 1);
        check("jmp_valid",  bus.em_valid, 1);
        check("jmp_shadow", bus.shadow_cnt, 3);
        bus.ie_jump      = 2'b00;
        bus.ie_reg_write = 1'b1;
        step();
        check("jmp_i1_rw", bus.em_reg_write, 0);
        check("jmp_i1_jump", bus.em_jump, 0);
        check("jmp_i1_sh", bus.shadow_cnt, 2);
        step();
        check("jmp_i2_rw", bus.em_reg_write, 0);
        check("jmp_i2_sh", bus.shadow_cnt, 1);
        step();
        check("jmp_i3_rw", bus.em_reg_write, 0);
        check("jmp_i3_sh", bus.shadow_cnt, 0);
        step();
        check("jmp_i4_rw",    bus.em_reg_write, 1);
        check("jmp_i4_valid", bus.em_valid, 1);
        check("jmp_i4_sh",    bus.shadow_cnt, 0);

        // Other branch types and boundary targets.
        clear_in();
        bus.ie_valid     = 1'b1;
        bus.ie_branch_op = 3'b100;   // blez, positive non-zero: not taken
        bus.ie_pc_plus4  = 32'h200;
        bus.ie_sign_imm  = 32'hFFFF_FFFF;
        step();
        check("blez_nt_redir", bus.em_redirect, 0);
        check("neg_imm_pc",    bus.em_pc_branch, 32'h1FC);
        check("blez_nt_sh",    bus.shadow_cnt, 0);
        bus.ie_branch_op = 3'b101;   // unused encoding: no branch
        bus.alu_zero     = 1'b1;
        bus.ie_pc_plus4  = 32'hFFFF_FFFC;
        bus.ie_sign_imm  = 32'h1;
        step();
        check("op101_redir", bus.em_redirect, 0);
        check("wrap_pc",     bus.em_pc_branch, 32'h0);
        bus.ie_branch_op = 3'b001;   // beq with zero: taken
        step();
        check("beq_redir", bus.em_redirect, 1);
        drain();
        check("drain_sh",    bus.shadow_cnt, 0);
        check("drain_redir", bus.em_redirect, 0);
        bus.ie_valid     = 1'b1;
        bus.ie_branch_op = 3'b011;   // bgtz, positive: taken
        step();
        check("bgtz_redir", bus.em_redirect, 1);
        drain();
        bus.ie_valid     = 1'b1;
        bus.ie_branch_op = 3'b100;   // blez, negative: taken
        bus.alu_sign     = 1'b1;
        step();
        check("blez_t_redir", bus.em_redirect, 1);
        drain();

        // Stall inside the shadow, with shadow_cnt = 1.
        bus.ie_valid = 1'b1;
        bus.ie_jump  = 2'b10;
        step();
        bus.ie_jump    = 2'b00;
        bus.alu_result = 32'hA1;
        step();
        bus.alu_result = 32'hA2;
        step();
        check("pre_stall_sh",  bus.shadow_cnt, 1);
        check("pre_stall_alu", bus.em_alu_result, 32'hA2);
        bus.stall        = 1'b1;
        bus.ie_reg_write = 1'b1;
        bus.alu_result   = 32'h999;
        step();
        step();
        check("stall_sh",    bus.shadow_cnt, 1);
        check("stall_alu",   bus.em_alu_result, 32'hA2);
        check("stall_valid", bus.em_valid, 0);
        bus.stall = 1'b0;
        step();
        check("unstall_valid", bus.em_valid, 0);
        check("unstall_rw",    bus.em_reg_write, 0);
        check("unstall_sh",    bus.shadow_cnt, 0);
        check("unstall_alu",   bus.em_alu_result, 32'h999);

        // Store-data forwarding.
        clear_in();
        bus.ie_valid      = 1'b1;
        bus.ie_mem_write  = 1'b1;
        bus.ie_mem_read   = 1'b1;
        bus.ie_mem_to_reg = 1'b1;
        bus.alu_result    = 32'hDEAD;
        bus.ie_reg_data2  = 32'h1234;
        bus.fw_wd_sel     = 2'd0;
        step();
        check("wd_sel0",  bus.em_write_data, 32'h1234);
        check("st_mw",    bus.em_mem_write, 1);
        check("st_mr",    bus.em_mem_read, 1);
        check("st_m2r",   bus.em_mem_to_reg, 1);
        bus.fw_wd_sel  = 2'd1;
        bus.alu_result = 32'h5555;
        step();
        check("wd_sel1",     bus.em_write_data, 32'hDEAD);
        check("wd_sel1_alu", bus.em_alu_result, 32'h5555);
        bus.fw_wd_sel  = 2'd2;
        bus.mw_wb_data = 32'hBEEF;
        step();
        check("wd_sel2", bus.em_write_data, 32'hBEEF);
        bus.fw_wd_sel = 2'd3;
        step();
        check("wd_sel3", bus.em_write_data, 0);

        // Flush and stall at the same edge while shadow_cnt = 2.
        clear_in();
        bus.ie_valid   = 1'b1;
        bus.ie_jump    = 2'b11;
        bus.alu_result = 32'h77;
        step();
        clear_in();
        bus.alu_result = 32'h78;
        step();
        check("pre_flush_sh", bus.shadow_cnt, 2);
        bus.flush      = 1'b1;
        bus.stall      = 1'b1;
        bus.ie_valid   = 1'b1;
        bus.alu_result = 32'h79;
        step();
        check("flush_valid", bus.em_valid, 0);
        check("flush_sh",    bus.shadow_cnt, 0);
        check("flush_alu",   bus.em_alu_result, 32'h78);
        bus.flush        = 1'b0;
        bus.stall        = 1'b0;
        bus.ie_mem_write = 1'b1;
        step();
        check("post_flush_mw",    bus.em_mem_write, 1);
        check("post_flush_valid", bus.em_valid, 1);

        // Reset in the middle of a shadow, with the jump still at the input.
        clear_in();
        bus.ie_valid = 1'b1;
        bus.ie_jump  = 2'b01;
        step();
        step();
        step();
        check("pre_rst_sh", bus.shadow_cnt, 1);
        rst = 1'b1;
        step();
        check("mid_rst_sh",    bus.shadow_cnt, 0);
        check("mid_rst_valid", bus.em_valid, 0);
        check("mid_rst_jump",  bus.em_jump, 0);
        check("mid_rst_alu",   bus.em_alu_result, 0);
        rst = 1'b0;
        bus.ie_jump      = 2'b00;
        bus.ie_reg_write = 1'b1;
        step();
        check("post_rst_rw",    bus.em_reg_write, 1);
        check("post_rst_valid", bus.em_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width; legal 32 or 64.
REQ-002 SHALL have parameter AW, default 5, register-address width.
REQ-003 SHALL have parameter SHADOW, default 1, captures killed after a redirect; legal 1..7.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports stall and flush  in  1 each  hold-stage / kill-stage requests.
REQ-007 SHALL have port ie_valid  in  1  EX holds a real instruction.
REQ-008 SHALL have ports ie_mem_write, ie_mem_read, ie_reg_write, ie_mem_to_reg, ie_reg_dst  in  1 each  EX control bits.
REQ-009 SHALL have ports ie_branch_op  in  3  (000 none, 001 beq, 010 bne, 011 bgtz, 100 blez, others none); ie_jump  in  2.
REQ-010 SHALL have ports alu_zero, alu_sign  in  1 each  flags for branch compare.
REQ-011 SHALL have ports ie_pc_plus4, ie_sign_imm, alu_result, ie_reg_data2, mw_wb_data  in  DW each; ie_jaddr  in  26; ie_rt, ie_rd  in  AW each.
REQ-012 SHALL have port fw_wd_sel  in  2  store-data source select.
REQ-013 SHALL have registered outputs em_valid, em_mem_write, em_mem_read, em_reg_write, em_mem_to_reg, em_redirect (1 each); em_jump (2); em_jaddr (26); em_wb_addr (AW); em_alu_result, em_write_data, em_pc_branch, em_pc_plus4 (DW each).
REQ-014 SHALL have output shadow_cnt  out  3  remaining kill slots.

Function
REQ-015 Capture SHALL occur on each rising edge with rst=0, flush=0, stall=0.
REQ-016 Priority SHALL be rst > flush > stall > capture.
REQ-017 With stall=1 (no flush), all outputs and shadow_cnt SHALL hold.
REQ-018 flush=1 SHALL clear em_valid, em_mem_write, em_mem_read, em_reg_write, em_redirect, em_jump and shadow_cnt; datapath outputs hold.
REQ-019 Captured instruction SHALL be "live" iff ie_valid=1 and shadow_cnt=0 at the edge.
REQ-020 Branch taken: beq=alu_zero; bne=!alu_zero; bgtz=!alu_sign & !alu_zero; blez=alu_sign|alu_zero.
REQ-021 On capture: em_valid<=live; em_mem_write, em_mem_read, em_reg_write<=input & live; em_redirect<=taken & live; em_jump<=live ? ie_jump : 0.
REQ-022 On capture, em_mem_to_reg, em_jaddr, em_pc_plus4, em_alu_result SHALL take EX inputs unconditionally.
REQ-023 em_wb_addr SHALL be ie_reg_dst ? ie_rd : ie_rt.
REQ-024 em_pc_branch SHALL be ie_pc_plus4 + (ie_sign_imm << 2), truncated to DW, no overflow flag.
REQ-025 em_write_data SHALL be sel 0: ie_reg_data2; 1: current em_alu_result (pre-edge); 2: mw_wb_data; 3: zero.
REQ-026 On capture of a live instruction that is a taken branch or has ie_jump!=0, shadow_cnt SHALL load SHADOW.
REQ-027 Otherwise on capture with shadow_cnt>0, shadow_cnt SHALL decrement by 1, never below 0.
REQ-028 A bubble (ie_valid=0) captured while shadow_cnt>0 SHALL consume a slot.
REQ-029 Latency EX->EM SHALL be exactly one capture edge; no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 at an edge SHALL zero every output including shadow_cnt, overriding stall/flush.
REQ-031 Reset mid-shadow SHALL abandon remaining kills; the first post-reset live instruction SHALL commit.

Verification
REQ-032 bne, alu_zero=0, pc_plus4=0x100, imm=0x4 -> em_redirect=1, em_pc_branch=0x110; next capture em_valid=0, em_reg_write=0.
REQ-033 SHADOW=3, jump (ie_jump=01) then 4 valid reg_write instructions -> first 3 captured with em_reg_write=0, 4th em_reg_write=1; shadow_cnt 3,2,1,0.
REQ-034 stall=1 for 2 cycles with shadow_cnt=1 -> outputs and shadow_cnt unchanged; released capture killed.
REQ-035 fw_wd_sel=1, em_alu_result=0xDEAD, ie_reg_data2=0x1234 -> em_write_data=0xDEAD; sel=2, mw_wb_data=0xBEEF -> 0xBEEF; sel=3 -> 0.
REQ-036 flush=1 and stall=1 same edge, shadow_cnt=2 -> em_valid=0, shadow_cnt=0; next live store sets em_mem_write=1.
REQ-037 rst=1 during shadow_cnt=1 with jump held at input -> all outputs 0; after release, first live capture with ie_reg_write=1 gives em_reg_write=1.
